// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: HI/LO registers, multi-cycle busy sequencing and D-stage stall.
// Optional macro MDU_FLUSH_EN adds a flush input that cancels a running op or suppresses a start.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_mdu,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        start_ok;
    logic        long_op;
    logic [63:0] mul_p0;
    logic [63:0] div_p0;

    // Extending both operands to 64 bits first makes the truncated product exact for signed and unsigned.
    function automatic logic [63:0] mul_res(input logic is_signed, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        eb = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Signed division via magnitudes: quotient truncates toward zero, remainder follows the dividend.
    function automatic logic [63:0] div_res(input logic is_signed, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] uq;
        logic [31:0] ur;
        logic        neg_a;
        logic        neg_b;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        ua = neg_a ? (32'd0 - a) : a;
        ub = neg_b ? (32'd0 - b) : b;
        if (ub == 32'd0) begin
            uq = 32'd0;
            ur = 32'd0;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
        end
        if (neg_a ^ neg_b) uq = 32'd0 - uq;
        if (neg_a)         ur = 32'd0 - ur;
        return {ur, uq};
    endfunction

`ifdef MDU_FLUSH_EN
    assign start_ok = start & ~flush;
`else
    assign start_ok = start;
`endif

    assign long_op = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
    assign busy    = (state == RUN);
    assign stall   = d_uses_mdu & (busy | (start & long_op));

    always_comb begin
        mul_p0 = mul_res(mdu_op == OP_MULT, rs_val, rt_val);
        div_p0 = div_res(mdu_op == OP_DIV, rs_val, rt_val);
    end

    always_comb begin
        rd_out = 32'd0;
        if (mdu_op == OP_MFHI)      rd_out = hi;
        else if (mdu_op == OP_MFLO) rd_out = lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        case (mdu_op)
                            OP_MULT, OP_MULTU: begin
                                {res_hi, res_lo} <= mul_p0;
                                cnt   <= MULT_LOAD;
                                state <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero completes by rewriting the current HI/LO.
                                if (rt_val == 32'd0) begin
                                    res_hi <= hi;
                                    res_lo <= lo;
                                end else begin
                                    {res_hi, res_lo} <= div_p0;
                                end
                                cnt   <= DIV_LOAD;
                                state <= RUN;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                default: begin
`ifdef MDU_FLUSH_EN
                    if (flush) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else
`endif
                    if (cnt == 4'd1) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: mult/div results, busy/stall timing, HI/LO moves and reset abort.
// With MDU_FLUSH_EN defined it also exercises the flush input.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_mdu;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_out;
`ifdef MDU_FLUSH_EN
    logic        flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdu_op    (mdu_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_uses_mdu(d_uses_mdu),
`ifdef MDU_FLUSH_EN
        .flush     (flush),
`endif
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        mdu_op = op;
        rs_val = a;
        rt_val = b;
    endtask

    task automatic idle_in();
        start  = 1'b0;
        mdu_op = 4'd0;
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        mdu_op     = 4'd0;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        d_uses_mdu = 1'b0;
`ifdef MDU_FLUSH_EN
        flush      = 1'b0;
`endif
        #3;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1'b1;

        // signed mult -2 * 3 with D-stage MDU user present
        d_uses_mdu = 1'b1;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        #1;
        chk("mult_stall_start", {31'd0, stall}, 32'd1);
        tick();
        idle_in();
        chk("mult_hi_hold", hi, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mult_busy_%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("mult_stall_%0d", i), {31'd0, stall}, 32'd1);
            tick();
        end
        chk("mult_busy_end", {31'd0, busy}, 32'd0);
        chk("mult_stall_end", {31'd0, stall}, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // combinational reads
        mdu_op = 4'd7; #1;
        chk("mfhi_rd", rd_out, 32'hFFFF_FFFF);
        mdu_op = 4'd8; #1;
        chk("mflo_rd", rd_out, 32'hFFFF_FFFA);
        mdu_op = 4'd9; #1;
        chk("op9_rd", rd_out, 32'd0);

        // divu 100 / 7 with no D-stage MDU user: stall stays low
        d_uses_mdu = 1'b0;
        issue(4'd4, 32'd100, 32'd7);
        #1;
        chk("divu_stall_start", {31'd0, stall}, 32'd0);
        tick();
        idle_in();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("divu_busy_%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("divu_stall_%0d", i), {31'd0, stall}, 32'd0);
            tick();
        end
        chk("divu_busy_end", {31'd0, busy}, 32'd0);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // signed div -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        tick();
        idle_in();
        repeat (9) tick();
        chk("div_busy_last", {31'd0, busy}, 32'd1);
        tick();
        chk("div_busy_end", {31'd0, busy}, 32'd0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // starts during RUN are ignored
        issue(4'd2, 32'd2, 32'd3);
        tick();
        issue(4'd5, 32'h0000_DEAD, 32'd0);
        tick();
        issue(4'd3, 32'd9, 32'd0);
        tick();
        idle_in();
        tick();
        tick();
        chk("ign_busy_last", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_busy_end", {31'd0, busy}, 32'd0);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd6);

        // mthi then mfhi
        issue(4'd5, 32'h1234_5678, 32'd0);
        tick();
        idle_in();
        mdu_op = 4'd7;
        #1;
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_rd", rd_out, 32'h1234_5678);

        // divide by zero leaves HI/LO untouched
        issue(4'd5, 32'd5, 32'd0);
        tick();
        issue(4'd6, 32'd6, 32'd0);
        tick();
        chk("mtlo_lo", lo, 32'd6);
        issue(4'd3, 32'd123, 32'd0);
        tick();
        idle_in();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("div0_busy_%0d", i), {31'd0, busy}, 32'd1);
            tick();
        end
        chk("div0_busy_end", {31'd0, busy}, 32'd0);
        chk("div0_hi", hi, 32'd5);
        chk("div0_lo", lo, 32'd6);

        // reset in busy cycle 3 aborts without a later completion write
        issue(4'd1, 32'h8000_0000, 32'd4);
        tick();
        idle_in();
        tick();
        tick();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        issue(4'd6, 32'h0000_00A5, 32'd0);
        tick();
        idle_in();
        chk("first_op_lo", lo, 32'h0000_00A5);
        repeat (6) tick();
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'h0000_00A5);

`ifdef MDU_FLUSH_EN
        issue(4'd2, 32'd2, 32'd3);
        tick();
        idle_in();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'h0000_00A5);
        flush = 1'b1;
        issue(4'd5, 32'h0000_0077, 32'd0);
        tick();
        issue(4'd1, 32'd2, 32'd3);
        tick();
        flush = 1'b0;
        idle_in();
        chk("flush_idle_hi", hi, 32'd0);
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
